// File: rtl/te_state_pkg.sv
// Shared layout of the per-channel state block and the fill/write-back sequencer encoding.
package te_state_pkg;

  localparam int unsigned ADDR_W       = 5;
  localparam int unsigned WB_FIRST_DEF = 6;
  localparam int unsigned WB_LAST_DEF  = 15;

  // Words 0..5 hold channel configuration, 6..15 hold dynamic state.
  localparam logic [ADDR_W-1:0] WORD_CFG_FIRST = 5'd0;
  localparam logic [ADDR_W-1:0] WORD_CFG_LAST  = 5'd5;
  localparam logic [ADDR_W-1:0] WORD_DYN_FIRST = 5'd6;
  localparam logic [ADDR_W-1:0] WORD_LAST      = 5'd15;

  typedef enum logic [2:0] {
    StIdle,
    StFill,
    StFlush,
    StProc,
    StWb
  } fill_state_e;

endpackage

// File: rtl/state_fill_ctrl.sv
// Channel state sequencer: fill from state memory, wait for processing, write back.
// Optional FILL_SKIP_CONFIG_EN lets a fill skip the config words unless reload_config is set.
module state_fill_ctrl
  import te_state_pkg::*;
#(
  parameter int unsigned CH_BITS  = 5,
  parameter int unsigned WB_FIRST = WB_FIRST_DEF,
  parameter int unsigned WB_LAST  = WB_LAST_DEF
) (
  input  logic               clk,
  input  logic               rst_b,
  input  logic               start,
  input  logic [CH_BITS-1:0] ch_id,
`ifdef FILL_SKIP_CONFIG_EN
  input  logic               reload_config,
`endif
  input  logic               mem_hold,
  input  logic               proc_done,
  input  logic               abort,
  output logic               fill_enable,
  output logic               state_rd,
  output logic               state_wr,
  output logic [ADDR_W-1:0]  state_addr,
  output logic [CH_BITS-1:0] state_ch,
  output logic               busy,
  output logic               fill_done,
  output logic               done
);

  localparam logic [ADDR_W-1:0] WbFirstAddr = ADDR_W'(WB_FIRST);
  localparam logic [ADDR_W-1:0] WbLastAddr  = ADDR_W'(WB_LAST);
  localparam logic [ADDR_W-1:0] AddrOne     = ADDR_W'(1);

  fill_state_e       state_q;
  logic [ADDR_W-1:0] start_addr;

  always_comb begin
`ifdef FILL_SKIP_CONFIG_EN
    start_addr = reload_config ? WORD_CFG_FIRST : WORD_DYN_FIRST;
`else
    start_addr = WORD_CFG_FIRST;
`endif
  end

  // Strobes follow mem_hold in the same cycle; abort suppresses the access it coincides with.
  assign fill_enable = (state_q == StFill);
  assign state_rd    = fill_enable && !mem_hold && !abort;
  assign state_wr    = (state_q == StWb) && !mem_hold && !abort;
  assign busy        = (state_q != StIdle);

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q    <= StIdle;
      state_addr <= '0;
      state_ch   <= '0;
      fill_done  <= 1'b0;
      done       <= 1'b0;
    end else begin
      fill_done <= 1'b0;
      done      <= 1'b0;
      if (abort && busy) begin
        state_q <= StIdle;
      end else begin
        case (state_q)
          StIdle: begin
            if (start) begin
              state_ch   <= ch_id;
              state_addr <= start_addr;
              state_q    <= StFill;
            end
          end
          StFill: begin
            if (state_rd) begin
              if (state_addr == WbLastAddr) state_q <= StFlush;
              else                          state_addr <= state_addr + AddrOne;
            end
          end
          StFlush: begin
            fill_done <= 1'b1;
            state_q   <= StProc;
          end
          StProc: begin
            if (proc_done) begin
              state_addr <= WbFirstAddr;
              state_q    <= StWb;
            end
          end
          StWb: begin
            if (state_wr) begin
              if (state_addr == WbLastAddr) begin
                done    <= 1'b1;
                state_q <= StIdle;
              end else begin
                state_addr <= state_addr + AddrOne;
              end
            end
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_state_fill_ctrl.sv
// Scoreboard bench for state_fill_ctrl: the driver predicts strobe/pulse events per cycle,
// a negedge monitor pops and compares them. Honours FILL_SKIP_CONFIG_EN when defined.
module tb_state_fill_ctrl;
  import te_state_pkg::*;

  localparam int unsigned CB = 5;
  localparam int LastWord  = 15;
  localparam int FirstWb   = 6;
`ifdef FILL_SKIP_CONFIG_EN
  localparam bit SkipEn = 1'b1;
`else
  localparam bit SkipEn = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_b = 1'b0;
  logic          start = 1'b0;
  logic [CB-1:0] ch_id = '0;
  logic          mem_hold = 1'b0;
  logic          proc_done = 1'b0;
  logic          abort = 1'b0;
`ifdef FILL_SKIP_CONFIG_EN
  logic          reload_config = 1'b0;
`endif
  logic          fill_enable, state_rd, state_wr, busy, fill_done, done;
  logic [4:0]    state_addr;
  logic [CB-1:0] state_ch;

  state_fill_ctrl #(.CH_BITS(CB)) dut (
    .clk         (clk),
    .rst_b       (rst_b),
    .start       (start),
    .ch_id       (ch_id),
`ifdef FILL_SKIP_CONFIG_EN
    .reload_config(reload_config),
`endif
    .mem_hold    (mem_hold),
    .proc_done   (proc_done),
    .abort       (abort),
    .fill_enable (fill_enable),
    .state_rd    (state_rd),
    .state_wr    (state_wr),
    .state_addr  (state_addr),
    .state_ch    (state_ch),
    .busy        (busy),
    .fill_done   (fill_done),
    .done        (done)
  );

  always #5 clk = ~clk;

  typedef enum int {EvRd, EvWr, EvFillDone, EvDone, EvIdle} ev_kind_e;
  typedef struct {
    ev_kind_e kind;
    int       addr;
    int       ch;
    int       cyc;
  } ev_t;

  ev_t exp_q[$];
  int  checks = 0;
  int  errors = 0;
  int  cyc = 0;
  bit  busy_prev = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0d required %0d", name, cyc, act, req);
    end
  endtask

  task automatic expect_ev(input ev_kind_e k, input int a, input int c);
    ev_t e;
    e.kind = k;
    e.addr = a;
    e.ch   = c;
    e.cyc  = cyc;
    exp_q.push_back(e);
  endtask

  task automatic observe(input ev_kind_e k, input int a, input int c);
    ev_t e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_event at cycle %0d: got kind %0d addr %0d required none", cyc,
               int'(k), a);
    end else begin
      e = exp_q.pop_front();
      chk("event_kind", int'(k), int'(e.kind));
      chk("event_cycle", cyc, e.cyc);
      chk("event_addr", a, e.addr);
      chk("event_ch", c, e.ch);
    end
  endtask

  always @(negedge clk) begin
    if (!rst_b) begin
      busy_prev = 1'b0;
    end else begin
      if (state_rd || state_wr) chk("rd_wr_exclusive", int'(state_rd && state_wr), 0);
      if (state_rd) observe(EvRd, int'(state_addr), int'(state_ch));
      if (state_wr) observe(EvWr, int'(state_addr), int'(state_ch));
      if (fill_done) observe(EvFillDone, 0, 0);
      if (done) observe(EvDone, 0, 0);
      if (busy_prev && !busy) observe(EvIdle, 0, 0);
      busy_prev = busy;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic bit rand_bit(input int pct);
    return int'($urandom_range(0, 99)) < pct;
  endfunction

  task automatic check_all_zero(input string tag);
    chk({tag, "_fill_enable"}, int'(fill_enable), 0);
    chk({tag, "_state_rd"}, int'(state_rd), 0);
    chk({tag, "_state_wr"}, int'(state_wr), 0);
    chk({tag, "_state_addr"}, int'(state_addr), 0);
    chk({tag, "_state_ch"}, int'(state_ch), 0);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_fill_done"}, int'(fill_done), 0);
    chk({tag, "_done"}, int'(done), 0);
  endtask

  task automatic noise();
    start     = rand_bit(25);
    ch_id     = CB'($urandom);
    proc_done = rand_bit(25);
  endtask

  // One sequence starting in the current (idle) cycle. Negative positions disable that event.
  task automatic run_txn(input int ch_sel, input bit reload, input int burst_at,
                         input int reset_at, input int abort_rd, input bit abort_proc,
                         input int abort_wr, input int hold_pct);
    int a;
    int ch;
    int burst_left;
    bit burst_used;
    bit acc;
    ch = (ch_sel < 0) ? int'($urandom_range(0, 31)) : ch_sel;
    a  = (SkipEn && !reload) ? 6 : 0;
`ifdef FILL_SKIP_CONFIG_EN
    reload_config = reload;
`endif
    start = 1'b1;
    ch_id = CB'(ch);
    proc_done = 1'b0;
    abort = 1'b0;
    mem_hold = rand_bit(hold_pct);
    tick();
    burst_left = 0;
    burst_used = 1'b0;
    forever begin
      noise();
      if (a == reset_at) begin
        rst_b = 1'b0;
        #1;
        check_all_zero("reset_mid_fill");
        tick();
        rst_b = 1'b1;
        return;
      end
      if (a == abort_rd) begin
        abort = 1'b1;
        mem_hold = rand_bit(50);
        tick();
        abort = 1'b0;
        expect_ev(EvIdle, 0, 0);
        return;
      end
      if (a == burst_at && !burst_used) begin
        burst_left = 3;
        burst_used = 1'b1;
      end
      mem_hold = (burst_left > 0) ? 1'b1 : rand_bit(hold_pct);
      if (burst_left > 0) burst_left--;
      acc = !mem_hold;
      if (acc) expect_ev(EvRd, a, ch);
      tick();
      if (acc) begin
        if (a == LastWord) break;
        a++;
      end
    end
    noise();
    mem_hold = rand_bit(hold_pct);
    tick();
    expect_ev(EvFillDone, 0, 0);
    repeat ($urandom_range(0, 3)) begin
      noise();
      proc_done = 1'b0;
      mem_hold = rand_bit(hold_pct);
      tick();
    end
    start = rand_bit(25);
    proc_done = 1'b1;
    abort = abort_proc;
    tick();
    proc_done = 1'b0;
    if (abort_proc) begin
      abort = 1'b0;
      expect_ev(EvIdle, 0, 0);
      return;
    end
    a = FirstWb;
    forever begin
      noise();
      if (a == abort_wr) begin
        abort = 1'b1;
        mem_hold = rand_bit(50);
        tick();
        abort = 1'b0;
        expect_ev(EvIdle, 0, 0);
        return;
      end
      mem_hold = rand_bit(hold_pct);
      acc = !mem_hold;
      if (acc) expect_ev(EvWr, a, ch);
      tick();
      if (acc) begin
        if (a == LastWord) break;
        a++;
      end
    end
    expect_ev(EvDone, 0, 0);
    expect_ev(EvIdle, 0, 0);
  endtask

  initial begin
    #12;
    check_all_zero("reset");
    tick();
    rst_b = 1'b1;
    tick();
    // ch 7, no stalls: 16 reads then 10 writes
    run_txn(7, 1'b1, -1, -1, -1, 1'b0, -1, 0);
    // three-cycle memory hold at fill word 4
    run_txn(-1, 1'b1, 4, -1, -1, 1'b0, -1, 0);
    // abort during write-back at word 9, then a fresh sequence
    run_txn(-1, 1'b1, -1, -1, -1, 1'b0, 9, 0);
    run_txn(3, 1'b1, -1, -1, -1, 1'b0, -1, 0);
    // abort coinciding with proc_done wins
    run_txn(-1, 1'b1, -1, -1, -1, 1'b1, -1, 0);
    // reset mid-fill at word 8, then restart from word 0
    run_txn(-1, 1'b1, -1, 8, -1, 1'b0, -1, 0);
    run_txn(-1, 1'b1, -1, -1, -1, 1'b0, -1, 0);
    // config skip, if built in
    run_txn(-1, 1'b0, -1, -1, -1, 1'b0, -1, 0);
    run_txn(-1, 1'b1, -1, -1, -1, 1'b0, -1, 0);
    for (int i = 0; i < 40; i++) begin
      run_txn(-1, rand_bit(50), -1, -1,
              rand_bit(12) ? int'($urandom_range(0, 15)) : -1,
              rand_bit(10),
              rand_bit(12) ? int'($urandom_range(6, 15)) : -1,
              25);
    end
    start = 1'b0;
    proc_done = 1'b0;
    mem_hold = 1'b0;
    abort = 1'b0;
    repeat (4) tick();
    chk("queue_drained", exp_q.size(), 0);
    chk("idle_at_end", int'(busy), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/state_fill_ctrl.md
STATE_FILL_CTRL -- requirements
Module: state_fill_ctrl

Interface
REQ-001 SHALL have parameter CH_BITS, default 5: physical channel index width.
REQ-002 SHALL have parameter WB_FIRST, default 6: first state word written back after processing.
REQ-003 SHALL have parameter WB_LAST, default 15: last state word written back, and last word filled.
REQ-004 clk  input  1  system clock.
REQ-005 rst_b  input  1  reset, asynchronous, active-low.
REQ-006 start  input  1  one-cycle pulse requesting a fill/process/write-back sequence.
REQ-007 ch_id  input  CH_BITS  channel to service, sampled on start.
REQ-008 reload_config  input  1  re-read config words 0..5, sampled on start; port present only with FILL_SKIP_CONFIG_EN.
REQ-009 mem_hold  input  1  state memory granted to another requester; sequencer stalls.
REQ-010 proc_done  input  1  one-cycle pulse: datapath finished processing the channel.
REQ-011 abort  input  1  one-cycle pulse: terminate the sequence without write-back.
REQ-012 fill_enable  output  1  high during FILL, drives fill_state fill_enable.
REQ-013 state_rd  output  1  state memory read strobe.
REQ-014 state_wr  output  1  state memory write strobe.
REQ-015 state_addr  output  5  word address within the channel state block.
REQ-016 state_ch  output  CH_BITS  latched channel index, upper memory address.
REQ-017 busy  output  1  high in any state other than IDLE.
REQ-018 fill_done  output  1  one-cycle pulse when the final fill load enable is produced.
REQ-019 done  output  1  one-cycle pulse when write-back completes.

Function
REQ-020 SHALL implement FSM states IDLE, FILL, FLUSH, PROC, WB.
REQ-021 IDLE: start SHALL latch ch_id into state_ch, set state_addr to the start word and enter FILL next cycle; start outside IDLE SHALL be ignored.
REQ-022 FILL: each cycle with mem_hold low SHALL assert state_rd with fill_enable and increment state_addr; the read at WB_LAST SHALL move the FSM to FLUSH.
REQ-023 FILL with mem_hold high SHALL deassert state_rd, hold state_addr and keep fill_enable high.
REQ-024 FLUSH SHALL last exactly one cycle, pulse fill_done, then enter PROC; fill_done is therefore 2 cycles after the last state_rd.
REQ-025 PROC SHALL hold all strobes low until proc_done, then enter WB with state_addr=WB_FIRST.
REQ-026 WB: each cycle with mem_hold low SHALL assert state_wr and increment state_addr; the write at WB_LAST SHALL pulse done the following cycle and return to IDLE.
REQ-027 WB with mem_hold high SHALL deassert state_wr and hold state_addr.
REQ-028 abort in any non-IDLE state SHALL return to IDLE next cycle with all strobes low, no done and no fill_done; abort has priority over proc_done and start in the same cycle.
REQ-029 state_rd and state_wr SHALL never be high simultaneously; a full sequence SHALL issue exactly 16 reads (or 10, see REQ-034) and WB_LAST-WB_FIRST+1 writes.
REQ-030 state_addr SHALL never exceed WB_LAST; no wrap-around occurs.
REQ-031 proc_done outside PROC SHALL be ignored.

Reset
REQ-032 rst_b low SHALL force IDLE and clear fill_enable, state_rd, state_wr, state_addr, state_ch, busy, fill_done and done to 0, including mid-sequence.

Configuration
REQ-033 Macro FILL_SKIP_CONFIG_EN SHALL select the config-skip feature.
REQ-034 With FILL_SKIP_CONFIG_EN defined and reload_config low at start, FILL SHALL start at word 6, and fill_state retains the config registers; with reload_config high it SHALL start at word 0.
REQ-035 Without FILL_SKIP_CONFIG_EN, the reload_config port SHALL be absent and FILL SHALL always start at word 0.

Structure
REQ-036 FSM state encoding, state-word addresses 0..15 and WB_FIRST/WB_LAST defaults SHALL be in shared package te_state_pkg.
REQ-037 SHALL be a single module with no sub-module; the address counter is shared between FILL and WB.

Verification
REQ-038 start, ch_id=7, no hold -> state_rd on 16 consecutive cycles, addr 0..15, state_ch=7, fill_done 2 cycles after addr 15.
REQ-039 proc_done in PROC -> state_wr on 10 consecutive cycles, addr 6..15, done one cycle after addr 15, busy low the following cycle.
REQ-040 mem_hold high for 3 cycles during FILL at addr 4 -> no strobe for 3 cycles, addr held at 4, sequence resumes at 4, total reads still 16.
REQ-041 abort at WB addr 9 -> IDLE next cycle, no done, no further state_wr; new start then accepted.
REQ-042 FILL_SKIP_CONFIG_EN defined, reload_config=0 -> reads addr 6..15 only (10 reads); reload_config=1 -> 16 reads.
REQ-043 rst_b low mid-FILL at addr 8 -> all outputs 0 immediately; start after release restarts at addr 0.
